// File: rtl/sync_fifo_if.sv
// sync_fifo push/pop handshake bundle.
// SYNC_FIFO_ERR_EN adds the sticky error flag.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_write;
    logic                  write;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  next_read;
    logic                  empty;
`ifdef SYNC_FIFO_ERR_EN
    logic                  error;

    modport master (
        output data_write, write, next_read,
        input  full, almost_full, data_read, empty, error
    );
    modport slave (
        input  data_write, write, next_read,
        output full, almost_full, data_read, empty, error
    );
`else
    modport master (
        output data_write, write, next_read,
        input  full, almost_full, data_read, empty
    );
    modport slave (
        input  data_write, write, next_read,
        output full, almost_full, data_read, empty
    );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, any NUM_SLOTS >= 2.
// SYNC_FIFO_ERR_EN adds a sticky overflow/underflow error flag.
module sync_fifo #(
    parameter int NUM_SLOTS     = 2,
    parameter int LOG_NUM_SLOTS = 1,
    parameter int DATA_WIDTH    = 32
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave fifo
);
    localparam int CW = LOG_NUM_SLOTS + 1;
    localparam logic [LOG_NUM_SLOTS-1:0] LAST =
        LOG_NUM_SLOTS'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_SLOTS);
    localparam logic [CW-1:0] CNT_AF   = CW'(NUM_SLOTS - 1);

    logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push, pop;
    logic                     full, empty;

    function automatic logic [LOG_NUM_SLOTS-1:0] nxt(
        input logic [LOG_NUM_SLOTS-1:0] p
    );
        // Explicit wrap: NUM_SLOTS need not be a power of two
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign push = fifo.write && (!full || fifo.next_read);
    assign pop  = fifo.next_read && !empty;

    assign fifo.full        = full;
    assign fifo.empty       = empty;
    assign fifo.almost_full = (count_q >= CNT_AF);
    assign fifo.data_read   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case (1'b1)
            push && !pop: count_d = count_q + 1'b1;
            pop && !push: count_d = count_q - 1'b1;
            default:      count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fifo.data_write;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic error_q, error_d;

    assign error_d = error_q
                   | (fifo.write && full && !fifo.next_read)
                   | (fifo.next_read && empty);
    assign fifo.error = error_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: 2-slot and 3-slot instances.
// Error-flag checks compile in with SYNC_FIFO_ERR_EN.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(32)) i2 ();
    sync_fifo_if #(.DATA_WIDTH(32)) i3 ();

    sync_fifo #(
        .NUM_SLOTS(2), .LOG_NUM_SLOTS(1), .DATA_WIDTH(32)
    ) u2 (.clk(clk), .rst(rst), .fifo(i2));

    sync_fifo #(
        .NUM_SLOTS(3), .LOG_NUM_SLOTS(2), .DATA_WIDTH(32)
    ) u3 (.clk(clk), .rst(rst), .fifo(i3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i2.write = 1'b0; i2.next_read = 1'b0; i2.data_write = '0;
        i3.write = 1'b0; i3.next_read = 1'b0; i3.data_write = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic push2(input logic [31:0] d);
        i2.write = 1'b1; i2.data_write = d;
        tick();
        i2.write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if (i2.empty !== 1'b1) begin
            nfail++; $display("FAIL reset_empty2: got %b exp 1", i2.empty);
        end
        nchk++;
        if (i2.full !== 1'b0) begin
            nfail++; $display("FAIL reset_full2: got %b exp 0", i2.full);
        end
        nchk++;
        if (i2.almost_full !== 1'b0) begin
            nfail++; $display("FAIL reset_af2: got %b exp 0", i2.almost_full);
        end
        nchk++;
        if (i3.empty !== 1'b1 || i3.full !== 1'b0 || i3.almost_full !== 1'b0) begin
            nfail++;
            $display("FAIL reset3: got e%b f%b af%b exp e1 f0 af0",
                     i3.empty, i3.full, i3.almost_full);
        end
`ifdef SYNC_FIFO_ERR_EN
        nchk++;
        if (i2.error !== 1'b0) begin
            nfail++; $display("FAIL reset_err: got %b exp 0", i2.error);
        end
`endif
    endtask

    task automatic test_push_pop();
        do_reset();
        push2(32'h11111111);
        nchk++;
        if (i2.empty !== 1'b0 || i2.almost_full !== 1'b1 || i2.full !== 1'b0) begin
            nfail++;
            $display("FAIL pp_flags1: got e%b af%b f%b exp e0 af1 f0",
                     i2.empty, i2.almost_full, i2.full);
        end
        nchk++;
        if (i2.data_read !== 32'h11111111) begin
            nfail++; $display("FAIL pp_head1: got %h exp 11111111", i2.data_read);
        end
        push2(32'h22222222);
        nchk++;
        if (i2.full !== 1'b1 || i2.data_read !== 32'h11111111) begin
            nfail++;
            $display("FAIL pp_full: got f%b d%h exp f1 d11111111",
                     i2.full, i2.data_read);
        end
        i2.next_read = 1'b1;
        tick();
        nchk++;
        if (i2.data_read !== 32'h22222222 || i2.full !== 1'b0) begin
            nfail++;
            $display("FAIL pp_pop1: got d%h f%b exp d22222222 f0",
                     i2.data_read, i2.full);
        end
        tick();
        i2.next_read = 1'b0;
        nchk++;
        if (i2.empty !== 1'b1) begin
            nfail++; $display("FAIL pp_empty: got %b exp 1", i2.empty);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push2(32'h11111111);
        push2(32'h22222222);
        push2(32'h00000033);
        nchk++;
        if (i2.full !== 1'b1 || i2.data_read !== 32'h11111111) begin
            nfail++;
            $display("FAIL ovf_drop: got f%b d%h exp f1 d11111111",
                     i2.full, i2.data_read);
        end
`ifdef SYNC_FIFO_ERR_EN
        nchk++;
        if (i2.error !== 1'b1) begin
            nfail++; $display("FAIL ovf_err: got %b exp 1", i2.error);
        end
`endif
        i2.next_read = 1'b1;
        tick();
        nchk++;
        if (i2.data_read !== 32'h22222222) begin
            nfail++; $display("FAIL ovf_second: got %h exp 22222222", i2.data_read);
        end
        tick();
        i2.next_read = 1'b0;
        nchk++;
        if (i2.empty !== 1'b1) begin
            nfail++; $display("FAIL ovf_empty: got %b exp 1", i2.empty);
        end
`ifdef SYNC_FIFO_ERR_EN
        nchk++;
        if (i2.error !== 1'b1) begin
            nfail++; $display("FAIL ovf_sticky: got %b exp 1", i2.error);
        end
        do_reset();
        nchk++;
        if (i2.error !== 1'b0) begin
            nfail++; $display("FAIL ovf_clr: got %b exp 0", i2.error);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push2(32'h11111111);
        push2(32'h22222222);
        i2.write = 1'b1; i2.next_read = 1'b1; i2.data_write = 32'h00000033;
        tick();
        idle();
        nchk++;
        if (i2.full !== 1'b1 || i2.data_read !== 32'h22222222) begin
            nfail++;
            $display("FAIL fpp_head: got f%b d%h exp f1 d22222222",
                     i2.full, i2.data_read);
        end
        i2.next_read = 1'b1;
        tick();
        nchk++;
        if (i2.data_read !== 32'h00000033 || i2.empty !== 1'b0) begin
            nfail++;
            $display("FAIL fpp_next: got d%h e%b exp d00000033 e0",
                     i2.data_read, i2.empty);
        end
        tick();
        i2.next_read = 1'b0;
        nchk++;
        if (i2.empty !== 1'b1) begin
            nfail++; $display("FAIL fpp_empty: got %b exp 1", i2.empty);
        end
`ifdef SYNC_FIFO_ERR_EN
        nchk++;
        if (i2.error !== 1'b0) begin
            nfail++; $display("FAIL fpp_err: got %b exp 0", i2.error);
        end
`endif
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        i2.write = 1'b1; i2.next_read = 1'b1; i2.data_write = 32'hDDDD0004;
        tick();
        idle();
        nchk++;
        if (i2.empty !== 1'b0 || i2.data_read !== 32'hDDDD0004) begin
            nfail++;
            $display("FAIL epp_head: got e%b d%h exp e0 dDDDD0004",
                     i2.empty, i2.data_read);
        end
        nchk++;
        if (i2.almost_full !== 1'b1 || i2.full !== 1'b0) begin
            nfail++;
            $display("FAIL epp_count1: got af%b f%b exp af1 f0",
                     i2.almost_full, i2.full);
        end
`ifdef SYNC_FIFO_ERR_EN
        nchk++;
        if (i2.error !== 1'b1) begin
            nfail++; $display("FAIL epp_err: got %b exp 1", i2.error);
        end
`endif
        i2.next_read = 1'b1;
        tick();
        i2.next_read = 1'b0;
        nchk++;
        if (i2.empty !== 1'b1) begin
            nfail++; $display("FAIL epp_empty: got %b exp 1", i2.empty);
        end
    endtask

    task automatic test_wrap3();
        logic [31:0] wr_pat;
        logic [31:0] rd_pat;
        logic [31:0] exp_q[$];
        int sent;
        int recv;
        int cnt;
        logic wr, rd, pu, po;
        wr_pat = 32'b1011_0111_0011_1101_1110_0101_1111_0111;
        rd_pat = 32'b0110_1001_1100_0110_0011_1010_0100_1000;
        sent = 0; recv = 0; cnt = 0;
        do_reset();
        for (int c = 0; c < 80 && recv < 10; c++) begin
            wr = (sent < 10) && ((c < 32) ? wr_pat[c] : 1'b1);
            rd = (c < 32) ? rd_pat[c] : 1'b1;
            nchk++;
            if (i3.empty !== (cnt == 0) || i3.full !== (cnt == 3)) begin
                nfail++;
                $display("FAIL wrap_flags c%0d: got e%b f%b exp cnt %0d",
                         c, i3.empty, i3.full, cnt);
            end
            po = rd && (cnt > 0);
            pu = wr && (cnt < 3 || rd);
            if (po) begin
                nchk++;
                if (i3.data_read !== exp_q[0]) begin
                    nfail++;
                    $display("FAIL wrap_data %0d: got %h exp %h",
                             recv, i3.data_read, exp_q[0]);
                end
                void'(exp_q.pop_front());
                recv++;
            end
            i3.write = wr;
            i3.next_read = rd;
            i3.data_write = 32'hA0 + 32'(sent);
            if (pu) begin
                exp_q.push_back(32'hA0 + 32'(sent));
                sent++;
            end
            cnt = cnt + (pu ? 1 : 0) - (po ? 1 : 0);
            tick();
        end
        idle();
        nchk++;
        if (recv != 10 || i3.empty !== 1'b1) begin
            nfail++;
            $display("FAIL wrap_done: got recv %0d e%b exp 10 e1",
                     recv, i3.empty);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_push_pop();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap3();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule
